led_fader: RTL and testbench
============================

# led_fader

Output stage placed directly downstream of the `Blink` instance. It consumes Blink's square-wave LED level and drives the physical LED with a PWM signal whose duty ramps smoothly up and down, giving a "breathing" LED. It is instantiated in `Top` between Blink's `led_o` and the top-level `led_o`.

## Interface
Parameters:
- `FREQ`, default 0: clock frequency in Hz. A value of 0 is illegal and must fail elaboration through the same generate-error pattern `Top` uses.
- `PWM_BITS`, default 8: width of the duty and PWM counter. `MAX = 2**PWM_BITS - 1`.
- `RAMP_MS`, default 250: time for a full 0→MAX ramp, in ms.

Ports:
- `clk_i`, input, 1: single clock.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `led_i`, input, 1: LED level from Blink, same clock domain.
- `led_o`, output, 1: PWM LED drive, registered.
- `duty_o`, output, `PWM_BITS`: current target duty.
- `busy_o`, output, 1: high while in RISE or FALL.

## Operation
- `STEP_DIV = max(1, (FREQ/1000)*RAMP_MS / MAX)`, computed with integer truncation at elaboration.
- `led_i` is registered once into `led_q`. The FSM acts only on `led_q`.
- A step counter counts 0..`STEP_DIV-1`. A step tick fires when it reaches `STEP_DIV-1`, and the counter then wraps to 0. It clears to 0 on every state change.
- FSM states (reset state OFF):
  - OFF: duty = 0. Go to RISE when `led_q=1`.
  - RISE: duty +1 per step tick. Go to ON when duty reaches MAX. Go to FALL when `led_q=0`, with duty kept at its current value (no jump).
  - ON: duty = MAX. Go to FALL when `led_q=0`.
  - FALL: duty −1 per step tick. Go to OFF when duty reaches 0. Go to RISE when `led_q=1`, with duty kept.
- Duty saturates at 0 and MAX and never wraps.
- If a step tick and a direction change occur in the same cycle, the transition wins and the duty does not step.
- PWM counter runs 0..MAX−1 and wraps (period = MAX cycles).
  - `duty_act` latches `duty` when the PWM counter is 0.
  - `led_o <= (pwm_cnt < duty_act)`.
  - Duty 0 gives `led_o` constantly 0. Duty MAX gives constantly 1.
- Reset values: `led_o=0`, `duty_o=0`, `busy_o=0`, state OFF, all counters 0, `led_q=0`.
- Reset asserted mid-ramp has the same effect as power-up reset on the next edge. There is no residual duty.

## Timing
- `led_i` edge at cycle t: `led_q` changes at t+1, and state changes at t+2.
- `busy_o` changes at t+2. `busy_o` is decoded from the registered state.
- First duty step lands at t+2+`STEP_DIV`.
- Full ramp: `MAX*STEP_DIV` cycles after state entry.
- `led_o` reflects a new duty at the next PWM counter wrap plus 1 cycle, so worst case MAX+1 cycles after `duty_o` changes.
- `duty_o` is registered and updates on the step-tick edge.

## Structure
- Package `led_pkg`:
  - FSM state enum {OFF, RISE, ON, FALL}.
  - Function computing `STEP_DIV` from `FREQ`/`RAMP_MS`/`PWM_BITS`.
- Sub-module `pwm_gen` (params `PWM_BITS`): PWM counter, `duty_act` latch, and comparator. It takes `clk_i`, `rst_i`, `duty_i` and produces `pwm_o`.
- `led_fader` holds the input register, step counter, and FSM.

## Test plan
Common configuration: `FREQ=2550000`, `RAMP_MS=1`, `PWM_BITS=8`, which gives `STEP_DIV=10` and `MAX=255`.

- Reset held 5 cycles with `led_i=1` → `led_o=0`, `duty_o=0`, `busy_o=0` throughout. After release, `busy_o=1` exactly 2 cycles later.
- `led_i` 0→1 and held → `duty_o` increments every 10 cycles, first step at t+12, and equals 255 at t+2552. `busy_o` then falls, and `led_o` is constantly 1 from the next PWM wrap onward.
- Hold `led_i=1` for 1000 cycles, then drive 0 → `duty_o` peaks at 99 or 100, then decrements by 1 every 10 cycles with no jump, reaches 0, and `busy_o` falls.
- During a ramp, sample each PWM period (255 cycles) → the count of `led_o=1` cycles equals the `duty_act` latched at that period's start. No period contains a mid-period duty change.
- Assert `rst_i` for 1 cycle at `duty_o=128` → next cycle `duty_o=0`, `led_o=0`, state OFF. With `led_i=1`, RISE restarts 2 cycles after release.
- Elaborate with `FREQ=0` → elaboration error.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and elaboration helpers for the LED fader.
// Contents:
//   fade_state_t   - fader FSM state encoding
//   calc_step_div  - cycles per duty step for a full 0..MAX ramp
package led_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } fade_state_t;

  // Integer truncation at every step, then clamp to at least one cycle
  // so that very short ramps or slow clocks still make progress.
  function automatic int unsigned calc_step_div(input int unsigned freq,
                                                input int unsigned ramp_ms,
                                                input int unsigned pwm_bits);
    longint unsigned max_val;
    longint unsigned div;
    max_val = (64'd1 << pwm_bits) - 64'd1;
    div     = (64'(freq / 32'd1000) * 64'(ramp_ms)) / max_val;
    return (div < 64'd1) ? 32'd1 : 32'(div);
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// PWM generator for the LED fader.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   duty_i - requested duty, 0..2**PWM_BITS-1
//   pwm_o  - registered PWM output
// The counter runs 0..MAX-1 so a period is MAX cycles; this makes duty 0
// constantly low and duty MAX constantly high.
module pwm_gen #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_o
);

  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = MAX - 1'b1;

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_duty_act;
  logic                r_pwm;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_duty_act <= '0;
      r_pwm      <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      // Duty is only taken at the period start so no period is ever split
      // between two duty values.
      if (r_cnt == '0) begin
        r_duty_act <= duty_i;
      end
      r_pwm <= (r_cnt < r_duty_act);
    end
  end

  assign pwm_o = r_pwm;

endmodule

// File: rtl/led_fader.sv
// Breathing-LED output stage: turns a square-wave LED level into a PWM
// drive whose duty ramps up while the level is high and down while low.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   led_i  - LED level from the blinker, same clock domain
//   led_o  - registered PWM LED drive
//   duty_o - current target duty
//   busy_o - high while ramping (RISE or FALL)
//
// state | meaning
// ------+-------------------------------------------------
// OFF   | duty held at 0, waiting for led level high
// RISE  | duty +1 per step tick until MAX
// ON    | duty held at MAX, waiting for led level low
// FALL  | duty -1 per step tick until 0
module led_fader
  import led_pkg::*;
#(
  parameter int unsigned FREQ     = 0,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned RAMP_MS  = 250
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                led_i,
  output logic                led_o,
  output logic [PWM_BITS-1:0] duty_o,
  output logic                busy_o
);

  generate
    if (FREQ == 0) begin : g_freq_check
      $error("led_fader: FREQ must be set to the clock frequency in Hz");
    end
  endgenerate

  localparam int unsigned STEP_DIV = calc_step_div(FREQ, RAMP_MS, PWM_BITS);
  localparam int unsigned CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0]    STEP_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX       = '1;

  logic                r_led_q;
  fade_state_t         r_state;
  fade_state_t         w_state_next;
  logic [CNT_W-1:0]    r_step_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic                w_tick;
  logic                w_busy;
  logic                w_stay;

  assign w_tick = (r_step_cnt == STEP_LAST);
  assign w_busy = (r_state == RISE) || (r_state == FALL);
  assign w_stay = (w_state_next == r_state);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      OFF:  if (r_led_q) w_state_next = RISE;
      RISE: begin
        if (!r_led_q)         w_state_next = FALL;
        else if (r_duty == MAX) w_state_next = ON;
      end
      ON:   if (!r_led_q) w_state_next = FALL;
      FALL: begin
        if (r_led_q)          w_state_next = RISE;
        else if (r_duty == '0) w_state_next = OFF;
      end
      default: w_state_next = OFF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_led_q    <= 1'b0;
      r_state    <= OFF;
      r_step_cnt <= '0;
      r_duty     <= '0;
    end else begin
      r_led_q <= led_i;
      r_state <= w_state_next;

      if (!w_stay || !w_busy || w_tick) begin
        r_step_cnt <= '0;
      end else begin
        r_step_cnt <= r_step_cnt + 1'b1;
      end

      // A direction change on a tick cycle suppresses the step, so a
      // reversal never moves the duty by an extra count.
      if (w_stay && w_tick) begin
        if (r_state == RISE && r_duty != MAX) begin
          r_duty <= r_duty + 1'b1;
        end else if (r_state == FALL && r_duty != '0) begin
          r_duty <= r_duty - 1'b1;
        end
      end
    end
  end

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .duty_i(r_duty),
    .pwm_o (led_o)
  );

  assign duty_o = r_duty;
  assign busy_o = w_busy;

endmodule

// File: tb/tb_led_fader.sv
module tb_led_fader;

  logic       clk_i;
  logic       rst_i;
  logic       led_i;
  logic       led_o;
  logic [7:0] duty_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  led_fader #(
    .FREQ    (2550000),
    .PWM_BITS(8),
    .RAMP_MS (1)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .led_i (led_i),
    .led_o (led_o),
    .duty_o(duty_o),
    .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required finish before 1 ms");
    $fatal(1, "watchdog");
  end

  // Expected duty k edges after a reset release with led_i driven high at
  // release: first step at edge 12, then one step every 10 edges, cap 255.
  function automatic int d_rise(input int k);
    int v;
    if (k < 12) return 0;
    v = (k - 12) / 10 + 1;
    return (v > 255) ? 255 : v;
  endfunction

  // led_i high at release, driven low after edge 1000: state enters FALL at
  // edge 1002 (tick there is suppressed), then -1 every 10 edges.
  function automatic int d_fall(input int k);
    int v;
    if (k <= 1001) return d_rise(k);
    v = d_rise(1001) - (k - 1002) / 10;
    return (v < 0) ? 0 : v;
  endfunction

  // Leaves the bench just after a reset edge with reset released.
  task automatic do_reset(input logic lvl);
    rst_i = 1'b1;
    led_i = lvl;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    led_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (led_o !== 1'b0 || duty_o !== 8'd0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: led=%b duty=%0d busy=%b, required 0/0/0",
                 i, led_o, duty_o, busy_o);
      end
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy_1: got %b, required 0", busy_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_busy_2: got %b, required 1", busy_o);
    end
  endtask

  task automatic test_rise;
    int ed;
    logic eb;
    do_reset(1'b0);
    led_i = 1'b1;
    for (int k = 1; k <= 3100; k++) begin
      @(posedge clk_i); #1;
      ed = d_rise(k);
      eb = (k >= 2 && k <= 2552);
      checks++;
      if (duty_o !== 8'(ed)) begin
        errors++;
        $display("FAIL rise_duty k=%0d: got %0d, required %0d", k, duty_o, ed);
        break;
      end
      checks++;
      if (busy_o !== eb) begin
        errors++;
        $display("FAIL rise_busy k=%0d: got %b, required %b", k, busy_o, eb);
        break;
      end
      if (k >= 2807) begin
        checks++;
        if (led_o !== 1'b1) begin
          errors++;
          $display("FAIL rise_led_full k=%0d: got %b, required 1", k, led_o);
          break;
        end
      end
    end
  endtask

  task automatic test_fall;
    int ed;
    int peak;
    logic eb;
    peak = 0;
    do_reset(1'b0);
    led_i = 1'b1;
    for (int k = 1; k <= 2320; k++) begin
      @(posedge clk_i); #1;
      if (int'(duty_o) > peak) peak = int'(duty_o);
      ed = d_fall(k);
      eb = (k >= 2 && k <= 1992);
      checks++;
      if (duty_o !== 8'(ed)) begin
        errors++;
        $display("FAIL fall_duty k=%0d: got %0d, required %0d", k, duty_o, ed);
        break;
      end
      checks++;
      if (busy_o !== eb) begin
        errors++;
        $display("FAIL fall_busy k=%0d: got %b, required %b", k, busy_o, eb);
        break;
      end
      if (k >= 2297) begin
        checks++;
        if (led_o !== 1'b0) begin
          errors++;
          $display("FAIL fall_led_zero k=%0d: got %b, required 0", k, led_o);
          break;
        end
      end
      if (k == 1000) led_i = 1'b0;
    end
    checks++;
    if (peak < 99 || peak > 100) begin
      errors++;
      $display("FAIL fall_peak: got %0d, required 99..100", peak);
    end
  endtask

  // PWM counter wraps at 255 edges after reset; duty latched at edge 255p+1
  // from the value after edge 255p shows on led_o after edges 255p+2..255p+256.
  task automatic test_pwm_periods;
    int acc;
    int p;
    int off;
    acc = 0;
    do_reset(1'b0);
    led_i = 1'b1;
    for (int k = 1; k <= 5 * 255 + 256; k++) begin
      @(posedge clk_i); #1;
      if (k >= 2) begin
        p   = (k - 2) / 255;
        off = (k - 2) % 255;
        if (p >= 1 && p <= 5) begin
          if (off == 0) acc = 0;
          acc += (led_o === 1'b1) ? 1 : 0;
          if (off == 254) begin
            checks++;
            if (acc != d_rise(255 * p)) begin
              errors++;
              $display("FAIL pwm_period %0d: high count %0d, required %0d",
                       p, acc, d_rise(255 * p));
            end
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    do_reset(1'b0);
    led_i = 1'b1;
    for (int k = 1; k <= 1285; k++) begin
      @(posedge clk_i); #1;
    end
    checks++;
    if (duty_o !== 8'd128) begin
      errors++;
      $display("FAIL midrst_pre_duty: got %0d, required 128", duty_o);
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (duty_o !== 8'd0 || led_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: duty=%0d led=%b busy=%b, required 0/0/0",
               duty_o, led_o, busy_o);
    end
    rst_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_i); #1;
      if (k == 1 || k == 2) begin
        checks++;
        if (busy_o !== (k == 2)) begin
          errors++;
          $display("FAIL midrst_busy k=%0d: got %b, required %b", k, busy_o, (k == 2));
        end
      end
      if (k == 11 || k == 12) begin
        checks++;
        if (duty_o !== 8'(d_rise(k))) begin
          errors++;
          $display("FAIL midrst_duty k=%0d: got %0d, required %0d", k, duty_o, d_rise(k));
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    led_i = 1'b0;
    test_reset();
    test_rise();
    test_fall();
    test_pwm_periods();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
